// File: rtl/pipe_skid_chain_pkg.sv
// Shared definitions for the elastic pipeline-register chain used between
// CPU pipeline stages.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [31:0] pipe_word_t;

  // Enough bits to count every entry of a full chain (two per stage).
  function automatic int occupancy_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_skid_chain_stage.sv
// One skid-buffered stage: a main entry feeding downstream plus a skid entry
// that absorbs the word in flight when downstream stalls.
module skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             up_xfer_s;
  logic             dn_xfer_s;

  // Next-state selection for the main and skid entries.
  always_comb begin
    up_xfer_s    = up_valid & ~skid_valid_q & ~flush;
    dn_xfer_s    = main_valid_q & dn_ready & ~flush;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = {WIDTH{1'b0}};
      skid_data_d  = {WIDTH{1'b0}};
    end else if (dn_xfer_s) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (up_xfer_s) begin
        main_data_d  = up_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (up_xfer_s) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = up_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = up_data;
      end
    end else begin
      main_valid_d = main_valid_q;
    end
  end

  // Entry registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= {WIDTH{1'b0}};
      skid_data_q  <= {WIDTH{1'b0}};
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  // Ready depends only on local state, cutting the backward ready path.
  assign up_ready = ~skid_valid_q;
  assign dn_valid = main_valid_q;
  assign dn_data  = main_data_q;

endmodule

// File: rtl/pipe_skid_chain.sv
// Elastic pipeline register: DEPTH chained skid stages with a synchronous
// flush and a registered count of held entries.
module pipe_skid_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 1,
  parameter int CNTW  = occupancy_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNTW-1:0]  occupancy
);

  logic             link_valid [DEPTH+1];
  logic [WIDTH-1:0] link_data  [DEPTH+1];
  logic             link_ready [DEPTH+1];
  logic             in_fire_s;
  logic             out_fire_s;
  logic [CNTW-1:0]  occupancy_q, occupancy_d;

  assign link_valid[0]     = in_valid;
  assign link_data[0]      = in_data;
  assign link_ready[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    skid_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (link_valid[k]),
      .up_data  (link_data[k]),
      .up_ready (link_ready[k]),
      .dn_valid (link_valid[k+1]),
      .dn_data  (link_data[k+1]),
      .dn_ready (link_ready[k+1])
    );
  end

  // Flush blocks both ends in the cycle it is asserted.
  assign in_ready   = link_ready[0] & ~flush;
  assign out_valid  = link_valid[DEPTH] & ~flush;
  assign out_data   = link_data[DEPTH];
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;
  assign occupancy  = occupancy_q;

  // Entry count: +1 per accepted word, -1 per delivered word.
  always_comb begin
    occupancy_d = occupancy_q;
    if (flush) begin
      occupancy_d = {CNTW{1'b0}};
    end else begin
      case ({in_fire_s, out_fire_s})
        2'b10:   occupancy_d = occupancy_q + {{(CNTW-1){1'b0}}, 1'b1};
        2'b01:   occupancy_d = occupancy_q - {{(CNTW-1){1'b0}}, 1'b1};
        default: occupancy_d = occupancy_q;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy_q <= {CNTW{1'b0}};
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

endmodule

// File: doc/pipe_skid_chain.md
# pipe_skid_chain

Parametrised elastic pipeline register: a chain of DEPTH skid-buffered stages carrying a WIDTH-bit payload under a valid/ready handshake, with a synchronous flush. It replaces the bare enable/clear pipeline flops between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Stall becomes backpressure (`out_ready` low) and pipeline clearance becomes `flush`. Full throughput is sustained, and every combinational ready path is cut at each stage.

## Interface
- `WIDTH`, default 32: payload width in bits, ≥1.
- `DEPTH`, default 1: number of chained skid stages, ≥1.
- `CNTW`, default `$clog2(2*DEPTH+1)`: width of `occupancy`. Derived; not overridden.
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `flush`, input, 1: synchronous clear of all stages (branch/exception squash).
- `in_valid`, input, 1: upstream payload valid.
- `in_data`, input, WIDTH: upstream payload.
- `in_ready`, output, 1: chain can accept this cycle.
- `out_valid`, output, 1: payload available at tail.
- `out_data`, output, WIDTH: tail payload.
- `out_ready`, input, 1: downstream accepts this cycle.
- `occupancy`, output, CNTW: total valid entries held, 0..2*DEPTH.

## Operation
- Each stage holds two entries: `main` (drives the stage output) and `skid`. Each entry has a valid bit and WIDTH data bits.
- Stage k's upstream port is `in_*` for k=0; otherwise it is stage k-1's output. Stage DEPTH-1 drives `out_*`.
- Per-stage handshake:
  - `s_ready` = ~skid_valid (registered, no combinational path from downstream ready).
  - Upstream transfer = up_valid & s_ready & ~flush.
  - Downstream transfer = main_valid & dn_ready & ~flush.
- Per-stage next state when flush=0:
  - Downstream transfer and skid_valid: main←skid; skid emptied; any upstream transfer is impossible (s_ready=0).
  - Downstream transfer, no skid, upstream transfer: main←incoming.
  - Downstream transfer only: main emptied.
  - No downstream transfer, upstream transfer, main empty: main←incoming.
  - No downstream transfer, upstream transfer, main full: skid←incoming.
  - Otherwise: hold.
- `out_valid` = tail main_valid & ~flush. `in_ready` = stage 0 s_ready & ~flush. No transfer on either side in a flush cycle.
- Flush: at the next edge all valid bits and all data registers go to 0, in every stage. Flush overrides all handshakes. Repeated flush cycles keep the chain empty.
- Reset (asynchronous): all valid and data registers go to 0 immediately, regardless of clk. It aborts any in-flight transfer. Outputs are valid-low on release.
- `occupancy`: registered. It updates each edge by +1 on an input transfer, −1 on an output transfer, 0 net on both. It is 0 on reset or flush.
- Ordering: strict FIFO; no payload dropped, duplicated or reordered absent flush.
- Payload is opaque; no arithmetic on it. Occupancy is width-safe by CNTW sizing with no wrap.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, occupancy=0.
- Latency: a payload accepted at edge t is first presented on `out_*` after edge t+DEPTH−1 (DEPTH cycles of registering) with an empty chain and out_ready held high.
- Throughput: 1 payload/cycle sustained with out_ready=1.
- Backpressure: after out_ready falls, in_ready falls after at most 2*DEPTH further accepted payloads. Capacity is 2*DEPTH; the chain is full at occupancy=2*DEPTH.
- Release: one cycle after out_ready rises on a full chain, out_valid remains 1. in_ready rises within DEPTH cycles.
- Simultaneous flush and reset: reset wins (asynchronous).
- Flush with in_valid=1: the input is not accepted (in_ready=0 that cycle); upstream must hold or discard it.
- All outputs are glitch-free registered functions, except for the `& ~flush` masking on in_ready/out_valid.

## Structure
- Sub-module `skid_stage` (WIDTH parameter; ports clk, reset, flush, up_valid/up_data/up_ready, dn_valid/dn_data/dn_ready), instantiated DEPTH times in a generate loop.
- Top level contains the generate chain, the flush masking and the occupancy counter.
- Shared package `pipe_pkg`:
  - Default width constant (32).
  - The `occupancy_width(depth)` function returning $clog2(2*depth+1).
  - The `pipe_word_t` typedef (logic [31:0]) used by CPU-stage instances.

## Test plan
- Reset mid-stream: DEPTH=2, WIDTH=8; fill 3 entries, assert reset between edges → out_valid=0, out_data=0, occupancy=0, in_ready=1 immediately; no output after release.
- Streaming: DEPTH=3, out_ready=1, send 0x01..0x10 one per cycle → 0x01 appears 3 cycles after acceptance, then one per cycle in order, in_ready constantly 1.
- Full/backpressure: DEPTH=2, out_ready=0, in_valid=1 with 0xA0.. → exactly 4 accepted (0xA0–0xA3), occupancy=4, in_ready=0; raise out_ready → 0xA0..0xA3 delivered in order, no bubble on output.
- Random stall: DEPTH=4, random in_valid/out_ready over 10k cycles, scoreboard → no loss/dup/reorder; occupancy equals scoreboard depth every cycle.
- Flush: DEPTH=2 holding 3 entries, flush=1 with in_valid=1 (0x55) → in_ready=0 and out_valid=0 that cycle; next cycle occupancy=0, out_data=0; 0x55 is never output.
- Simultaneous: full chain, out_ready=1 and in_valid=1 in the same cycle → tail is popped, occupancy unchanged or decremented per skid rule, never exceeds 2*DEPTH.
